result_mem_writer: RTL and testbench



---
 rtl/result_mem_pkg.sv | 34 +++
 rtl/result_word_fifo.sv | 51 +++++
 rtl/result_mem_writer.sv | 157 +++++++++++++++
 tb/tb_result_mem_writer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_mem_pkg.sv
// Shared types for the result-memory writer: FIFO entry layout, FSM encodings
// and the byteenable helper used when a partial word is flushed.
package result_mem_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int RES_ADDR_W     = 17;
  localparam int RES_DATA_W     = 32;
  localparam int MASK_W         = BYTES_PER_WORD + 1;

  typedef struct packed {
    logic [RES_ADDR_W-1:0]     addr;
    logic [RES_DATA_W-1:0]     data;
    logic [BYTES_PER_WORD-1:0] be;
    logic                      last;
  } res_entry_t;

  typedef enum logic {
    WAIT_SOF,
    IN_FRAME
  } frame_state_t;

  typedef enum logic {
    IDLE,
    WRITE
  } avl_state_t;

  // Contiguous low-lane byteenable for a word holding 'lanes' bytes (1..4).
  function automatic logic [BYTES_PER_WORD-1:0] lane_mask(input logic [2:0] lanes);
    logic [MASK_W-1:0] m;
    m = (MASK_W'(1) << lanes) - MASK_W'(1);
    return m[BYTES_PER_WORD-1:0];
  endfunction

endpackage

// File: rtl/result_word_fifo.sv
// First-word-fall-through FIFO of packed result words; the head entry is
// visible combinationally whenever the FIFO is not empty.
module result_word_fifo
  import result_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  res_entry_t push_data,
  input  logic       pop,
  output res_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  res_entry_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/result_mem_writer.sv
// Packs the 8-bit depth-map stream into little-endian 32-bit words and writes
// them to the result memory through an Avalon-MM master, FIFO-buffered.
module result_mem_writer
  import result_mem_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          AVL_DATA_W = 32,
  parameter int          ADDR_W     = 17,
  parameter int          FIFO_DEPTH = 16,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  input  logic                  sof_i,
  input  logic                  eof_i,
  output logic [ADDR_W-1:0]     avl_address_o,
  output logic [AVL_DATA_W-1:0] avl_writedata_o,
  output logic [3:0]            avl_byteenable_o,
  output logic                  avl_write_o,
  input  logic                  avl_waitrequest_i,
  output logic                  frame_done_o,
  output logic                  overflow_o,
  input  logic                  clr_status_i
);

  frame_state_t          frame_state, frame_next;
  logic [1:0]            lane, lane_next;
  logic [AVL_DATA_W-1:0] acc, acc_next;
  logic [ADDR_W-1:0]     addr, addr_next;

  logic                  beat;
  logic [1:0]            cur_lane;
  logic [AVL_DATA_W-1:0] cur_acc;
  logic [ADDR_W-1:0]     cur_addr;
  logic [AVL_DATA_W-1:0] packed_word;

  logic                  push;
  res_entry_t            push_entry;
  res_entry_t            head;
  logic                  fifo_full;
  logic                  fifo_empty;

  avl_state_t            avl_state, avl_next;
  logic                  load;
  logic                  accept;
  logic                  cur_last;

  // sof always restarts packing, even mid-frame, so the partial word is lost.
  assign beat     = data_valid_i && (sof_i || frame_state == IN_FRAME);
  assign cur_lane = sof_i ? 2'd0 : lane;
  assign cur_acc  = sof_i ? '0 : acc;
  assign cur_addr = sof_i ? ADDR_W'(BASE_ADDR) : addr;
  assign packed_word = cur_acc
                     | (AVL_DATA_W'(data_i) << {cur_lane, 3'b000});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_state <= WAIT_SOF;
      lane        <= '0;
      acc         <= '0;
      addr        <= ADDR_W'(BASE_ADDR);
    end else begin
      frame_state <= frame_next;
      lane        <= lane_next;
      acc         <= acc_next;
      addr        <= addr_next;
    end
  end

  always_comb begin
    frame_next = frame_state;
    lane_next  = lane;
    acc_next   = acc;
    addr_next  = addr;
    push       = 1'b0;
    push_entry = '0;
    if (beat) begin
      frame_next = eof_i ? WAIT_SOF : IN_FRAME;
      if (eof_i || cur_lane == 2'd3) begin
        push            = 1'b1;
        push_entry.addr = cur_addr;
        push_entry.data = packed_word;
        push_entry.be   = lane_mask({1'b0, cur_lane} + 3'd1);
        push_entry.last = eof_i;
        acc_next        = '0;
        lane_next       = '0;
        // Wraps modulo 2^ADDR_W; dropped words still consume their address.
        addr_next       = cur_addr + ADDR_W'(1);
      end else begin
        acc_next  = packed_word;
        lane_next = cur_lane + 2'd1;
        addr_next = cur_addr;
      end
    end
  end

  result_word_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (accept),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign accept = avl_write_o && !avl_waitrequest_i;
  assign load   = (avl_state == IDLE) && !fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) avl_state <= IDLE;
    else          avl_state <= avl_next;
  end

  always_comb begin
    avl_next = avl_state;
    case (avl_state)
      IDLE:    if (load)   avl_next = WRITE;
      WRITE:   if (accept) avl_next = IDLE;
      default: avl_next = IDLE;
    endcase
  end

  // The head entry stays in the FIFO until the slave accepts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avl_address_o    <= '0;
      avl_writedata_o  <= '0;
      avl_byteenable_o <= '0;
      avl_write_o      <= 1'b0;
      cur_last         <= 1'b0;
      frame_done_o     <= 1'b0;
      overflow_o       <= 1'b0;
    end else begin
      if (load) begin
        avl_address_o    <= head.addr;
        avl_writedata_o  <= head.data;
        avl_byteenable_o <= head.be;
        avl_write_o      <= 1'b1;
        cur_last         <= head.last;
      end else if (accept) begin
        avl_write_o <= 1'b0;
      end
      frame_done_o <= accept && cur_last;
      if (push && fifo_full && !accept) overflow_o <= 1'b1;
      else if (clr_status_i)            overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_mem_writer.sv
// Directed and randomized bench for result_mem_writer; expected memory writes
// come from chunking each accepted frame's bytes into little-endian words.
module tb_result_mem_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  data_i = '0;
  logic        data_valid_i = 1'b0;
  logic        sop_i = 1'b0;
  logic        eop_i = 1'b0;
  logic        sof_i = 1'b0;
  logic        eof_i = 1'b0;
  logic [16:0] avl_address_o;
  logic [31:0] avl_writedata_o;
  logic [3:0]  avl_byteenable_o;
  logic        avl_write_o;
  logic        wait_req = 1'b0;
  logic        frame_done_o;
  logic        overflow_o;
  logic        clr_status_i = 1'b0;

  result_mem_writer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .data_i            (data_i),
    .data_valid_i      (data_valid_i),
    .sop_i             (sop_i),
    .eop_i             (eop_i),
    .sof_i             (sof_i),
    .eof_i             (eof_i),
    .avl_address_o     (avl_address_o),
    .avl_writedata_o   (avl_writedata_o),
    .avl_byteenable_o  (avl_byteenable_o),
    .avl_write_o       (avl_write_o),
    .avl_waitrequest_i (wait_req),
    .frame_done_o      (frame_done_o),
    .overflow_o        (overflow_o),
    .clr_status_i      (clr_status_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          last;
  } exp_t;

  typedef struct {
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          cyc;
  } obs_t;

  exp_t       exp_q[$];
  obs_t       obs_q[$];
  int         done_q[$];
  logic [7:0] frame_bytes[$];
  int         tests = 0;
  int         fails = 0;
  int         fourth_cyc;

  // Accepted writes and frame_done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    obs_t o;
    if (reset_n && avl_write_o && !wait_req) begin
      o.addr = avl_address_o;
      o.data = avl_writedata_o;
      o.be   = avl_byteenable_o;
      o.cyc  = cyc;
      obs_q.push_back(o);
    end
    if (reset_n && frame_done_o) done_q.push_back(cyc);
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic sf,
                               input logic ef, input logic sp, input logic ep);
    @(posedge clk);
    #1;
    data_valid_i = v;
    data_i       = d;
    sof_i        = sf;
    eof_i        = ef;
    sop_i        = sp;
    eop_i        = ep;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic randomFrame(input int len);
    frame_bytes.delete();
    for (int i = 0; i < len; i++) frame_bytes.push_back(8'($urandom));
  endtask

  // Reference: bytes chunked four at a time, lane k = byte 4w+k, addresses from 0.
  task automatic modelFrame();
    int n;
    int words;
    exp_t e;
    n = frame_bytes.size();
    words = (n + 3) / 4;
    for (int w = 0; w < words; w++) begin
      int cnt;
      e.data = '0;
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
        if (4*w + k < n) begin
          e.data = e.data | (32'(frame_bytes[4*w + k]) << (8*k));
          cnt++;
        end
      end
      e.be   = 4'((1 << cnt) - 1);
      e.addr = 17'(w);
      e.last = (w == words - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic sendFrame(input bit gaps, input bit rand_wait);
    int n;
    n = frame_bytes.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idleCycle();
      applyStimulus(1'b1, frame_bytes[i], i == 0, i == n - 1, (i % 8) == 0, (i % 8) == 7);
      if (rand_wait) wait_req = ($urandom_range(0, 9) < 3);
      if (i == 3) fourth_cyc = cyc;
    end
    idleCycle();
  endtask

  task automatic drain();
    int quiet;
    quiet = 0;
    wait_req = 1'b0;
    for (int i = 0; i < 1000 && quiet < 4; i++) begin
      idleCycle();
      if (!avl_write_o) quiet++;
      else quiet = 0;
    end
    checkOutput("drain_timeout", 64'(quiet < 4), 64'(0));
  endtask

  task automatic compareAll(input string name);
    int n;
    int lasts;
    int k;
    lasts = 0;
    foreach (exp_q[i]) if (exp_q[i].last) lasts++;
    checkOutput({name, "_word_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    checkOutput({name, "_done_count"}, 64'(done_q.size()), 64'(lasts));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    k = 0;
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_w%0d_addr", name, i), 64'(obs_q[i].addr), 64'(exp_q[i].addr));
      checkOutput($sformatf("%s_w%0d_data", name, i), 64'(obs_q[i].data), 64'(exp_q[i].data));
      checkOutput($sformatf("%s_w%0d_be", name, i), 64'(obs_q[i].be), 64'(exp_q[i].be));
      if (exp_q[i].last && k < done_q.size()) begin
        checkOutput({name, "_done_cycle"}, 64'(done_q[k]), 64'(obs_q[i].cyc + 1));
        k++;
      end
    end
    exp_q.delete();
    obs_q.delete();
    done_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_write", 64'(avl_write_o), 64'(0));
    checkOutput("rst_addr", 64'(avl_address_o), 64'(0));
    checkOutput("rst_data", 64'(avl_writedata_o), 64'(0));
    checkOutput("rst_be", 64'(avl_byteenable_o), 64'(0));
    checkOutput("rst_done", 64'(frame_done_o), 64'(0));
    checkOutput("rst_ovf", 64'(overflow_o), 64'(0));
    reset_n = 1'b1;
    idleCycle();

    // 8-byte ramp, no wait: two full words, first write two cycles after byte 4.
    frame_bytes.delete();
    for (int i = 0; i < 8; i++) frame_bytes.push_back(8'(i));
    modelFrame();
    sendFrame(1'b0, 1'b0);
    drain();
    if (obs_q.size() > 0) checkOutput("latency", 64'(obs_q[0].cyc), 64'(fourth_cyc + 2));
    compareAll("ramp8");

    // 6-byte frame: trailing half word with be=3.
    frame_bytes.delete();
    for (int i = 0; i < 6; i++) frame_bytes.push_back(8'(8'h10 + i));
    modelFrame();
    sendFrame(1'b0, 1'b0);
    drain();
    compareAll("ramp6");

    // Single beat carrying both sof and eof.
    frame_bytes.delete();
    frame_bytes.push_back(8'hA5);
    modelFrame();
    sendFrame(1'b0, 1'b0);
    drain();
    compareAll("single");

    // 64 bytes with a 10-cycle waitrequest stall mid-frame.
    randomFrame(64);
    modelFrame();
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, frame_bytes[i], i == 0, i == 63, 1'b0, 1'b0);
      if (i == 24) wait_req = 1'b1;
      if (i == 34) wait_req = 1'b0;
    end
    idleCycle();
    checkOutput("stall_no_ovf", 64'(overflow_o), 64'(0));
    drain();
    compareAll("stall64");

    // 80 bytes with waitrequest stuck: only the first 16 words survive.
    wait_req = 1'b1;
    randomFrame(80);
    modelFrame();
    repeat (4) void'(exp_q.pop_back());
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b1, frame_bytes[i], i == 0, i == 79, 1'b0, 1'b0);
      if (i == 64) checkOutput("ovf_at_16", 64'(overflow_o), 64'(0));
      if (i == 68) checkOutput("ovf_at_17", 64'(overflow_o), 64'(1));
    end
    idleCycle();
    drain();
    compareAll("ovf80");
    checkOutput("ovf_sticky", 64'(overflow_o), 64'(1));
    @(posedge clk);
    #1;
    clr_status_i = 1'b1;
    @(posedge clk);
    #1;
    clr_status_i = 1'b0;
    checkOutput("ovf_cleared", 64'(overflow_o), 64'(0));

    // Pre-sof beats are ignored; sof three bytes in restarts the frame.
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 8'($urandom), 1'b0, i == 2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hE0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0, 1'b0);
    randomFrame(11);
    modelFrame();
    sendFrame(1'b0, 1'b0);
    drain();
    compareAll("restart");

    // Back-to-back random frames with gaps and random waitrequest.
    for (int f = 0; f < 6; f++) begin
      randomFrame($urandom_range(1, 30));
      modelFrame();
      sendFrame(1'b1, 1'b1);
    end
    drain();
    compareAll("random");

    // Reset while a write is stalled: outputs clear at once, FIFO is flushed.
    wait_req = 1'b1;
    randomFrame(8);
    sendFrame(1'b0, 1'b0);
    for (int i = 0; i < 20 && !avl_write_o; i++) idleCycle();
    checkOutput("write_pending", 64'(avl_write_o), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_write", 64'(avl_write_o), 64'(0));
    checkOutput("async_rst_addr", 64'(avl_address_o), 64'(0));
    wait_req = 1'b0;
    obs_q.delete();
    done_q.delete();
    repeat (2) idleCycle();
    reset_n = 1'b1;
    idleCycle();
    randomFrame(12);
    modelFrame();
    sendFrame(1'b0, 1'b0);
    drain();
    compareAll("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
